// File: rtl/dst_mac_framer.sv
// Egress framer: prepends a 3-word destination MAC header carrying the requested port, then passes payload through to tlast.
// Optional DST_MAC_INVALID_INJECT_EN adds dest_tuser to force bits [15:14] of the first header word to 2'b11.
module dst_mac_framer #(
  parameter logic [15:0] MAC_W2 = 16'h0200,
  parameter logic [15:0] MAC_W1 = 16'h0000,
  parameter logic [15:0] MAC_W0 = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  dest_tdata,
  input  logic        dest_tvalid,
  output logic        dest_tready,
`ifdef DST_MAC_INVALID_INJECT_EN
  input  logic        dest_tuser,
`endif
  input  logic [15:0] in_tdata,
  input  logic        in_tvalid,
  input  logic        in_tlast,
  output logic        in_tready,
  output logic [15:0] out_tdata,
  output logic        out_tvalid,
  output logic        out_tlast,
  input  logic        out_tready,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {IDLE, HDR2, HDR1, HDR0, PAYLOAD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  port_q, port_d;
  logic [15:0] frame_count_q;
  logic        frame_done;
  logic [15:0] hdr2_word;

`ifdef DST_MAC_INVALID_INJECT_EN
  logic inj_q, inj_d;

  always_ff @(posedge clk) begin
    if (!reset) inj_q <= 1'b0;
    else        inj_q <= inj_d;
  end

  always_comb begin
    inj_d = inj_q;
    if (reset && state_q == IDLE && dest_tvalid) inj_d = dest_tuser;
  end

  assign hdr2_word = inj_q ? {2'b11, MAC_W2[13:0]} : MAC_W2;
`else
  assign hdr2_word = MAC_W2;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      port_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
    end
  end

  // Counter only updates on reset or completion, so it holds otherwise.
  always_ff @(posedge clk) begin
    if (!reset)          frame_count_q <= 16'h0000;
    else if (frame_done) frame_count_q <= frame_count_q + 16'h0001;
  end

  assign frame_count = frame_count_q;

  // Outputs are gated by reset so all valids/readies read low while it is held.
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    dest_tready = 1'b0;
    in_tready   = 1'b0;
    out_tvalid  = 1'b0;
    out_tlast   = 1'b0;
    out_tdata   = 16'h0000;
    frame_done  = 1'b0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          dest_tready = 1'b1;
          if (dest_tvalid) begin
            port_d  = dest_tdata;
            state_d = HDR2;
          end
        end
        HDR2: begin
          out_tvalid = 1'b1;
          out_tdata  = hdr2_word;
          if (out_tready) state_d = HDR1;
        end
        HDR1: begin
          out_tvalid = 1'b1;
          out_tdata  = MAC_W1;
          if (out_tready) state_d = HDR0;
        end
        HDR0: begin
          out_tvalid = 1'b1;
          out_tdata  = {MAC_W0[15:2], port_q};
          if (out_tready) state_d = PAYLOAD;
        end
        PAYLOAD: begin
          out_tdata  = in_tdata;
          out_tvalid = in_tvalid;
          out_tlast  = in_tlast;
          in_tready  = out_tready;
          if (in_tvalid && out_tready && in_tlast) begin
            frame_done = 1'b1;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dst_mac_framer.sv
// Scoreboard bench for dst_mac_framer: randomized frames, queue-based expected stream, decoupled monitor.
module tb_dst_mac_framer;

  localparam logic [15:0] W2 = 16'h0200;
  localparam logic [15:0] W1 = 16'h0000;
  localparam logic [15:0] W0 = 16'h0000;

  logic        clk;
  logic        reset;
  logic [1:0]  dest_tdata;
  logic        dest_tvalid;
  logic        dest_tready;
  logic        dest_tuser;
  logic [15:0] in_tdata;
  logic        in_tvalid;
  logic        in_tlast;
  logic        in_tready;
  logic [15:0] out_tdata;
  logic        out_tvalid;
  logic        out_tlast;
  logic        out_tready;
  logic [15:0] frame_count;

  dst_mac_framer dut (
    .clk         (clk),
    .reset       (reset),
    .dest_tdata  (dest_tdata),
    .dest_tvalid (dest_tvalid),
    .dest_tready (dest_tready),
`ifdef DST_MAC_INVALID_INJECT_EN
    .dest_tuser  (dest_tuser),
`endif
    .in_tdata    (in_tdata),
    .in_tvalid   (in_tvalid),
    .in_tlast    (in_tlast),
    .in_tready   (in_tready),
    .out_tdata   (out_tdata),
    .out_tvalid  (out_tvalid),
    .out_tlast   (out_tlast),
    .out_tready  (out_tready),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  // Expected output stream: {tlast, tdata}
  logic [16:0] exp_q[$];
  int          hs_cyc[$];
  int          dest_cyc[$];
  logic [15:0] exp_count;

  logic [1:0]  fr_port[$];
  bit          fr_inj[$];
  logic [16:0] fr_words[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard on every output handshake and checks stall stability and first-header latency.
  initial begin
    bit          stall_prev = 1'b0;
    logic [17:0] stall_val = '0;
    bit          dhs_prev = 1'b0;
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        stall_prev = 1'b0;
        dhs_prev   = 1'b0;
      end else begin
        if (dhs_prev) chk("hdr2_latency_valid", {31'd0, out_tvalid}, 32'd1);
        if (stall_prev) chk("stall_hold", {14'd0, out_tvalid, out_tlast, out_tdata}, {14'd0, stall_val});
        if (out_tvalid && out_tready) begin
          hs_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h with no word expected", out_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("out_word", {15'd0, out_tlast, out_tdata}, {15'd0, e});
          end
        end
        stall_prev = out_tvalid && !out_tready;
        stall_val  = {out_tvalid, out_tlast, out_tdata};
        dhs_prev   = dest_tvalid && dest_tready;
        if (dhs_prev) dest_cyc.push_back(cyc);
      end
    end
  end

  // Reference model: a frame is its header (derived from port/inject) followed by its payload words.
  task automatic add_frame(input logic [1:0] port, input bit inj, input int len,
                           input bit fixed, input logic [15:0] w0, input logic [15:0] w1);
    logic [15:0] w;
    fr_port.push_back(port);
    fr_inj.push_back(inj);
    exp_q.push_back({1'b0, inj ? {2'b11, W2[13:0]} : W2});
    exp_q.push_back({1'b0, W1});
    exp_q.push_back({1'b0, W0[15:2], port});
    for (int i = 0; i < len; i++) begin
      if (fixed) w = (i == 0) ? w0 : w1;
      else       w = 16'($urandom);
      fr_words.push_back({(i == len - 1), w});
      exp_q.push_back({(i == len - 1), w});
    end
    exp_count = exp_count + 16'd1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frames(input int mode, input int gap_max);
    bit done = 1'b0;
    int k = 0;
    fork
      begin
        fork
          begin
            while (fr_port.size() > 0) begin
              int t = 0;
              dest_tvalid = 1'b0;
              repeat ($urandom_range(0, gap_max)) step();
              dest_tvalid = 1'b1;
              dest_tdata  = fr_port.pop_front();
              dest_tuser  = fr_inj.pop_front();
              do begin @(negedge clk); t++; end while (!(dest_tvalid && dest_tready) && t < 3000);
              if (t >= 3000) chk("dest_timeout", 32'd0, 32'd1);
              step();
              dest_tvalid = 1'b0;
              dest_tdata  = 2'($urandom);
            end
          end
          begin
            while (fr_words.size() > 0) begin
              int t = 0;
              logic [16:0] w;
              in_tvalid = 1'b0;
              in_tdata  = 16'($urandom);
              in_tlast  = 1'($urandom);
              repeat ($urandom_range(0, gap_max)) step();
              w = fr_words.pop_front();
              in_tvalid = 1'b1;
              in_tdata  = w[15:0];
              in_tlast  = w[16];
              do begin @(negedge clk); t++; end while (!(in_tvalid && in_tready) && t < 3000);
              if (t >= 3000) chk("payload_timeout", 32'd0, 32'd1);
              step();
              in_tvalid = 1'b0;
              in_tlast  = 1'b0;
            end
          end
        join
        done = 1'b1;
      end
      begin
        while (!done) begin
          case (mode)
            0:       out_tready = 1'b1;
            1:       out_tready = ($urandom_range(0, 3) != 0);
            default: out_tready = (k % 3 == 0);
          endcase
          k++;
          step();
        end
        out_tready = 1'b1;
      end
    join
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) step();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
  endtask

  task automatic clear_marks();
    hs_cyc.delete();
    dest_cyc.delete();
  endtask

  initial begin
    reset = 1'b0;
    dest_tdata = 2'b00; dest_tvalid = 1'b0; dest_tuser = 1'b0;
    in_tdata = 16'h0; in_tvalid = 1'b0; in_tlast = 1'b0;
    out_tready = 1'b1;
    exp_count = 16'd0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk("rst_out_tvalid", {31'd0, out_tvalid}, 32'd0);
    chk("rst_out_tlast", {31'd0, out_tlast}, 32'd0);
    chk("rst_in_tready", {31'd0, in_tready}, 32'd0);
    chk("rst_dest_tready", {31'd0, dest_tready}, 32'd0);
    chk("rst_out_tdata", {16'd0, out_tdata}, 32'd0);
    chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("idle_dest_tready", {31'd0, dest_tready}, 32'd1);
    chk("idle_out_tvalid", {31'd0, out_tvalid}, 32'd0);
    step();
    mon_en = 1'b1;

    // Basic frame, port 2, continuous ready
    clear_marks();
    add_frame(2'b10, 1'b0, 2, 1'b1, 16'hAAAA, 16'hBBBB);
    run_frames(0, 0);
    chk("basic_hs_count", hs_cyc.size(), 32'd5);
    if (hs_cyc.size() == 5) chk("basic_consecutive", hs_cyc[4] - hs_cyc[0], 32'd4);
    chk("basic_frame_count", {16'd0, frame_count}, {16'd0, exp_count});

    // Same frame under 1,0,0 backpressure
    clear_marks();
    add_frame(2'b10, 1'b0, 2, 1'b1, 16'hAAAA, 16'hBBBB);
    run_frames(2, 0);
    chk("stall_hs_count", hs_cyc.size(), 32'd5);

    // Back-to-back frames, ports 1 and 3
    clear_marks();
    add_frame(2'b01, 1'b0, 1, 1'b0, 16'h0, 16'h0);
    add_frame(2'b11, 1'b0, 1, 1'b0, 16'h0, 16'h0);
    run_frames(0, 0);
    chk("b2b_hs_count", hs_cyc.size(), 32'd8);
    if (hs_cyc.size() == 8) chk("b2b_gap", hs_cyc[4] - hs_cyc[3], 32'd2);
    chk("b2b_frame_count", {16'd0, frame_count}, {16'd0, exp_count});

    // Randomized traffic
    for (int i = 0; i < 40; i++)
      add_frame(2'($urandom), 1'b0, $urandom_range(1, 4), 1'b0, 16'h0, 16'h0);
    run_frames(1, 3);
    chk("rand_frame_count", {16'd0, frame_count}, {16'd0, exp_count});

    // Reset during HDR1
    mon_en = 1'b0;
    out_tready = 1'b1;
    dest_tvalid = 1'b1;
    dest_tdata = 2'b01;
    @(negedge clk);
    chk("mid_dest_hs", {31'd0, dest_tready}, 32'd1);
    step();
    dest_tvalid = 1'b0;
    @(negedge clk);
    chk("mid_hdr2", {15'd0, out_tvalid, out_tdata}, {15'd0, 1'b1, W2});
    step();
    @(negedge clk);
    chk("mid_hdr1", {15'd0, out_tvalid, out_tdata}, {15'd0, 1'b1, W1});
    reset = 1'b0;
    step();
    @(negedge clk);
    chk("mid_rst_tvalid", {31'd0, out_tvalid}, 32'd0);
    chk("mid_rst_dest_tready", {31'd0, dest_tready}, 32'd0);
    chk("mid_rst_frame_count", {16'd0, frame_count}, 32'd0);
    step();
    reset = 1'b1;
    exp_count = 16'd0;
    @(negedge clk);
    chk("mid_release_dest_tready", {31'd0, dest_tready}, 32'd1);
    step();
    mon_en = 1'b1;
    add_frame(2'b00, 1'b0, 1, 1'b0, 16'h0, 16'h0);
    run_frames(0, 1);
    chk("post_rst_frame_count", {16'd0, frame_count}, {16'd0, exp_count});

    // Counter wrap: preload just below the wrap point
    @(negedge clk);
    force dut.frame_count_q = 16'hFFFE;
    #1;
    release dut.frame_count_q;
    exp_count = 16'hFFFE;
    step();
    add_frame(2'b01, 1'b0, 1, 1'b0, 16'h0, 16'h0);
    run_frames(0, 0);
    chk("wrap_ffff", {16'd0, frame_count}, {16'd0, exp_count});
    add_frame(2'b10, 1'b0, 1, 1'b0, 16'h0, 16'h0);
    run_frames(1, 1);
    chk("wrap_zero", {16'd0, frame_count}, 32'd0);

`ifdef DST_MAC_INVALID_INJECT_EN
    add_frame(2'b00, 1'b1, 1, 1'b0, 16'h0, 16'h0);
    add_frame(2'b00, 1'b0, 1, 1'b0, 16'h0, 16'h0);
    run_frames(0, 0);
    chk("inject_frame_count", {16'd0, frame_count}, {16'd0, exp_count});
`endif

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
